// File: rtl/ofdm_preamble_inserter_pkg.sv
// Shared types and constants for the OFDM TX preamble inserter.
// State encodings, sc16 field widths and settings-bus register offsets.
package ofdm_preamble_inserter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int SC16_W   = 16;
  localparam int SAMPLE_W = 2 * SC16_W;

  localparam int DEFAULT_WINDOW_LEN   = 64;
  localparam int DEFAULT_PREAMBLE_LEN = 160;

  localparam logic [7:0] SR_PREAMBLE_ADDR = 8'd0;
  localparam logic [7:0] SR_PREAMBLE_DATA = 8'd1;
  localparam logic [7:0] SR_GAP_LEN       = 8'd2;

endpackage

// File: rtl/ofdm_preamble_inserter_if.sv
// Settings bus, payload input stream, radio output stream and frame pulses.
// master drives stimulus/settings and o_tready; slave is the inserter.
interface ofdm_preamble_inserter_if
  import ofdm_preamble_inserter_pkg::*;
();
  logic                set_stb;
  logic [7:0]          set_addr;
  logic [31:0]         set_data;

  logic [SAMPLE_W-1:0] i_tdata;
  logic                i_tlast;
  logic                i_tvalid;
  logic                i_tready;

  logic [SAMPLE_W-1:0] o_tdata;
  logic                o_tlast;
  logic                o_tvalid;
  logic                o_tready;

  logic                sof;
  logic                eof;

  modport master (
    output set_stb, set_addr, set_data,
    output i_tdata, i_tlast, i_tvalid,
    input  i_tready,
    input  o_tdata, o_tlast, o_tvalid,
    output o_tready,
    input  sof, eof
  );

  modport slave (
    input  set_stb, set_addr, set_data,
    input  i_tdata, i_tlast, i_tvalid,
    output i_tready,
    output o_tdata, o_tlast, o_tvalid,
    input  o_tready,
    output sof, eof
  );
endinterface

// File: rtl/ofdm_preamble_inserter_ram.sv
// Preamble storage: simple dual-port RAM, one write port and one registered read port.
// Read data appears the cycle after re and holds otherwise, so it doubles as a prefetch stage.
module ofdm_preamble_ram
  import ofdm_preamble_inserter_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_PREAMBLE_LEN,
  parameter  int WIDTH = SAMPLE_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ofdm_preamble_inserter.sv
// Prepends a host-loaded preamble to each tlast-delimited payload burst, then a zero gap.
// state    | meaning
// IDLE     | waiting for a burst; a pending tlast beat may still be draining
// PREAMBLE | streaming RAM[0..PREAMBLE_LEN-1] via the RAM read register
// PAYLOAD  | input samples passed through the output register
// GAP      | emitting gap_cnt zero samples, tlast on the final one
module ofdm_preamble_inserter
  import ofdm_preamble_inserter_pkg::*;
#(
  parameter int PREAMBLE_LEN = DEFAULT_PREAMBLE_LEN
) (
  input logic clk,
  input logic reset,
  input logic clear,
  ofdm_preamble_inserter_if.slave bus
);
  localparam int AW = $clog2(PREAMBLE_LEN);
  localparam int CW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(PREAMBLE_LEN);

  state_t              state;
  logic [AW-1:0]       ptr;
  logic [15:0]         gap_len;
  logic [15:0]         gap_cnt;
  logic [CW-1:0]       cnt;
  logic                pre_valid;
  logic                pre_last_out;
  logic                first_pending;

  logic [SAMPLE_W-1:0] out_data;
  logic                out_valid;
  logic                out_last;
  logic                out_first;

  logic [SAMPLE_W-1:0] ram_rdata;
  logic [AW-1:0]       ram_raddr;
  logic                ram_we;
  logic                ram_re;

  logic                adv;
  logic                out_fire;
  logic                in_ready;
  logic                in_fire;
  logic                start;
  logic                pre_load;
  logic                pre_refill;

  // The output register may take a new beat whenever it is empty or being consumed.
  assign adv        = ~out_valid | bus.o_tready;
  assign out_fire   = out_valid & bus.o_tready;
  assign in_ready   = (state == PAYLOAD) & adv;
  assign in_fire    = in_ready & bus.i_tvalid;
  assign start      = (state == IDLE) & bus.i_tvalid;
  assign pre_load   = (state == PREAMBLE) & adv & pre_valid;
  assign pre_refill = (state == PREAMBLE) & (~pre_valid | pre_load) & (cnt != CNT_END);

  assign ram_we    = bus.set_stb & (bus.set_addr == SR_PREAMBLE_DATA);
  assign ram_re    = start | pre_refill;
  assign ram_raddr = start ? '0 : cnt[AW-1:0];

  ofdm_preamble_ram #(
    .DEPTH (PREAMBLE_LEN),
    .WIDTH (SAMPLE_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ptr),
    .wdata (bus.set_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // ptr wraps at PREAMBLE_LEN-1 so the RAM depth need not be a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      gap_len <= '0;
    end else if (bus.set_stb) begin
      if (bus.set_addr == SR_PREAMBLE_ADDR) begin
        ptr <= bus.set_data[AW-1:0];
      end else if (bus.set_addr == SR_PREAMBLE_DATA) begin
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
      end else if (bus.set_addr == SR_GAP_LEN) begin
        gap_len <= bus.set_data[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      gap_cnt       <= '0;
      pre_valid     <= 1'b0;
      pre_last_out  <= 1'b0;
      first_pending <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_first     <= 1'b0;
    end else if (clear) begin
      state         <= IDLE;
      cnt           <= '0;
      pre_valid     <= 1'b0;
      pre_last_out  <= 1'b0;
      first_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_first     <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_first <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (bus.i_tvalid) begin
            cnt       <= CW'(1);
            pre_valid <= 1'b1;
            state     <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          if (pre_load) begin
            out_valid    <= 1'b1;
            out_data     <= ram_rdata;
            pre_last_out <= (cnt == CNT_END);
          end
          if (pre_refill) begin
            cnt       <= cnt + CW'(1);
            pre_valid <= 1'b1;
          end else if (pre_load) begin
            pre_valid <= 1'b0;
          end
          // Payload is only admitted once the last preamble beat has left the register.
          if (pre_last_out && out_fire) begin
            pre_last_out  <= 1'b0;
            first_pending <= 1'b1;
            cnt           <= '0;
            state         <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (in_fire) begin
            out_valid     <= 1'b1;
            out_data      <= bus.i_tdata;
            out_first     <= first_pending;
            first_pending <= 1'b0;
            if (bus.i_tlast && gap_len == 16'd0) begin
              out_last <= 1'b1;
              state    <= IDLE;
            end else if (bus.i_tlast) begin
              gap_cnt <= gap_len;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (adv) begin
            out_valid <= 1'b1;
            out_data  <= '0;
            out_last  <= (gap_cnt == 16'd1);
            gap_cnt   <= gap_cnt - 16'd1;
            if (gap_cnt == 16'd1) state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.i_tready = in_ready;
  assign bus.o_tdata  = out_data;
  assign bus.o_tvalid = out_valid;
  assign bus.o_tlast  = out_last;
  assign bus.sof      = out_fire & out_first;
  assign bus.eof      = out_fire & out_last;
endmodule

// File: tb/tb_ofdm_preamble_inserter.sv
// Bench for ofdm_preamble_inserter: burst-level output model plus literal spot checks.
module tb_ofdm_preamble_inserter;
  localparam int PRE = 160;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic        sof;
    logic        eof;
  } exp_t;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } src_t;

  logic clk;
  logic reset;
  logic clear;
  ofdm_preamble_inserter_if bus ();

  ofdm_preamble_inserter #(.PREAMBLE_LEN(PRE)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  src_t src_q[$];
  logic [31:0] ram_m [PRE];
  int   ptr_m = 0;
  int   gap_m = 0;

  int valid_pct = 100;
  int ready_pct = 100;
  logic src_flush = 1'b0;
  logic in_fire_s = 1'b0;
  logic rise_armed = 1'b0;
  int   rise_cyc = 0;

  logic mon_en = 1'b0;
  logic first_valid_armed = 1'b0;
  int   first_valid_cyc = 0;
  int   out_count, last_idx, sof_idx, eof_idx, last_cnt, sof_cnt, both_cnt, rdy_cycles;
  logic [31:0] log_data [1024];
  logic stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic reset_stats();
    out_count = 0; last_idx = 0; sof_idx = 0; eof_idx = 0;
    last_cnt = 0; sof_cnt = 0; both_cnt = 0; rdy_cycles = 0;
    for (int i = 0; i < 1024; i++) log_data[i] = '0;
  endtask

  // Whole burst as the output must appear: preamble image, payload, then gap zeros.
  task automatic add_burst(input int n, input int id);
    exp_t e;
    src_t s;
    for (int k = 0; k < PRE; k++) begin
      e = '{d: ram_m[k], last: 1'b0, sof: 1'b0, eof: 1'b0};
      exp_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      s.d = {8'(id), 8'(k), 16'(k * 7 + id)};
      s.last = (k == n - 1);
      src_q.push_back(s);
      e.d = s.d;
      e.sof = (k == 0);
      e.last = s.last && (gap_m == 0);
      e.eof = e.last;
      exp_q.push_back(e);
    end
    for (int k = 0; k < gap_m; k++) begin
      e = '{d: 32'd0, last: (k == gap_m - 1), sof: 1'b0, eof: (k == gap_m - 1)};
      exp_q.push_back(e);
    end
  endtask

  task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.set_stb = 1'b1; bus.set_addr = a; bus.set_data = d;
    @(posedge clk); #1;
    bus.set_stb = 1'b0;
    if (a == 8'd0) ptr_m = int'(d[7:0]);
    else if (a == 8'd1) begin
      ram_m[ptr_m] = d;
      ptr_m = (ptr_m == PRE - 1) ? 0 : ptr_m + 1;
    end else if (a == 8'd2) gap_m = int'(d[15:0]);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: %0d samples outstanding, expected 0", exp_q.size());
      exp_q.delete();
      src_flush = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_count(input int target, input int budget);
    int i = 0;
    while (out_count < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (out_count < target) begin
      n_vec++; n_bad++;
      $display("FAIL count_timeout: got %0d outputs expected %0d", out_count, target);
    end
  endtask

  // Source and sink drivers.
  always @(negedge clk) in_fire_s = bus.i_tvalid && bus.i_tready;

  initial begin
    logic hold;
    bus.i_tvalid = 1'b0; bus.i_tdata = '0; bus.i_tlast = 1'b0; bus.o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (src_flush) begin
        src_q.delete();
        src_flush = 1'b0;
        bus.i_tvalid = 1'b0;
      end else begin
        if (in_fire_s && src_q.size() > 0) void'(src_q.pop_front());
        hold = bus.i_tvalid && !in_fire_s && src_q.size() > 0;
        if (src_q.size() > 0 && (hold || $urandom_range(99) < valid_pct)) begin
          if (rise_armed) begin
            rise_cyc = cyc;
            rise_armed = 1'b0;
          end
          bus.i_tvalid = 1'b1;
          bus.i_tdata = src_q[0].d;
          bus.i_tlast = src_q[0].last;
        end else begin
          bus.i_tvalid = 1'b0;
        end
      end
      bus.o_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Compare process: every output handshake against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (stall_prev)
        chk("axi_hold", 64'({bus.o_tvalid, bus.o_tlast, bus.o_tdata}), 64'({1'b1, prev_last, prev_data}));
      if (first_valid_armed && bus.o_tvalid) begin
        first_valid_cyc = cyc;
        first_valid_armed = 1'b0;
      end
      if (bus.o_tvalid && bus.o_tready) begin
        out_count++;
        if (out_count < 1024) log_data[out_count] = bus.o_tdata;
        if (bus.o_tlast) begin last_idx = out_count; last_cnt++; end
        if (bus.sof) begin sof_idx = out_count; sof_cnt++; end
        if (bus.eof) eof_idx = out_count;
        if (bus.sof && bus.eof && bus.o_tlast) both_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_output: got %h with nothing expected", bus.o_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("stream", 64'({bus.o_tdata, bus.o_tlast, bus.sof, bus.eof}), 64'({e.d, e.last, e.sof, e.eof}));
        end
      end else begin
        chk("pulse_idle", 64'({bus.sof, bus.eof}), 64'd0);
      end
      if (bus.i_tready) rdy_cycles++;
      stall_prev = bus.o_tvalid && !bus.o_tready;
      prev_data = bus.o_tdata;
      prev_last = bus.o_tlast;
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0;
    bus.set_stb = 1'b0; bus.set_addr = '0; bus.set_data = '0;
    reset_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({bus.o_tvalid, bus.o_tlast, bus.o_tdata, bus.sof, bus.eof, bus.i_tready}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    mon_en = 1'b1;

    sr_write(8'd0, 32'd0);
    for (int n = 0; n < PRE; n++) sr_write(8'd1, {16'(n), ~(16'(n))});
    sr_write(8'd2, 32'd0);

    // Ramp preamble, 10-sample burst, no gap.
    reset_stats();
    first_valid_armed = 1'b1;
    rise_armed = 1'b1;
    add_burst(10, 1);
    wait_drain(2000);
    chk("t1_count", 64'(out_count), 64'd170);
    chk("t1_last_idx", 64'(last_idx), 64'd170);
    chk("t1_last_cnt", 64'(last_cnt), 64'd1);
    chk("t1_sof_idx", 64'(sof_idx), 64'd161);
    chk("t1_eof_idx", 64'(eof_idx), 64'd170);
    chk("t1_latency", 64'(first_valid_cyc - rise_cyc), 64'd2);
    chk("t1_first", 64'(log_data[1]), 64'h0000_FFFF);
    chk("t1_pre_end", 64'(log_data[160]), 64'h009F_FF60);
    chk("t1_payload0", 64'(log_data[161]), 64'h0100_0001);
    chk("t1_ready_cycles", 64'(rdy_cycles), 64'd10);

    // 4-sample burst followed by a 5-sample gap.
    sr_write(8'd2, 32'd5);
    reset_stats();
    add_burst(4, 2);
    wait_drain(2000);
    chk("t2_count", 64'(out_count), 64'd169);
    chk("t2_last_idx", 64'(last_idx), 64'd169);
    chk("t2_last_cnt", 64'(last_cnt), 64'd1);
    chk("t2_payload3", 64'(log_data[164]), 64'h0203_0017);
    chk("t2_gap_first", 64'(log_data[165]), 64'd0);
    chk("t2_ready_cycles", 64'(rdy_cycles), 64'd4);

    // Back-to-back bursts under random valid/ready.
    sr_write(8'd2, 32'd2);
    reset_stats();
    valid_pct = 70; ready_pct = 50;
    add_burst(1, 3);
    add_burst(37, 4);
    add_burst(200, 5);
    wait_drain(20000);
    valid_pct = 100; ready_pct = 100;
    chk("t3_count", 64'(out_count), 64'd724);
    chk("t3_last_cnt", 64'(last_cnt), 64'd3);
    chk("t3_sof_cnt", 64'(sof_cnt), 64'd3);

    // Single-sample burst with no gap: sof and eof coincide on the tlast beat.
    sr_write(8'd2, 32'd0);
    reset_stats();
    add_burst(1, 6);
    wait_drain(2000);
    chk("t4_count", 64'(out_count), 64'd161);
    chk("t4_sof_eof_same", 64'(both_cnt), 64'd1);

    // Pointer wrap: 158, 159, 0, then 1.
    sr_write(8'd0, 32'd158);
    sr_write(8'd1, 32'hCAFE_0158);
    sr_write(8'd1, 32'hCAFE_0159);
    sr_write(8'd1, 32'hCAFE_0000);
    sr_write(8'd1, 32'hCAFE_0001);
    reset_stats();
    add_burst(2, 7);
    wait_drain(2000);
    chk("t5_ram0", 64'(log_data[1]), 64'hCAFE_0000);
    chk("t5_ram1", 64'(log_data[2]), 64'hCAFE_0001);
    chk("t5_ram2", 64'(log_data[3]), 64'h0002_FFFD);
    chk("t5_ram158", 64'(log_data[159]), 64'hCAFE_0158);
    chk("t5_ram159", 64'(log_data[160]), 64'hCAFE_0159);

    // clear in the middle of the preamble.
    reset_stats();
    add_burst(5, 8);
    wait_count(50, 500);
    @(posedge clk); #2;
    clear = 1'b1; src_flush = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_clear_valid", 64'(bus.o_tvalid), 64'd0);
    repeat (3) @(negedge clk);
    reset_stats();
    add_burst(3, 9);
    wait_drain(2000);
    chk("t6_restart_ram0", 64'(log_data[1]), 64'hCAFE_0000);
    chk("t6_count", 64'(out_count), 64'd163);

    // reset in the middle of the payload.
    reset_stats();
    add_burst(20, 10);
    wait_count(165, 500);
    @(posedge clk); #2;
    reset = 1'b1; src_flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    gap_m = 0; ptr_m = 0;
    @(negedge clk);
    chk("t6_reset_outputs", 64'({bus.o_tvalid, bus.o_tlast, bus.o_tdata, bus.sof, bus.eof, bus.i_tready}), 64'd0);
    repeat (3) @(negedge clk);
    reset_stats();
    add_burst(2, 11);
    wait_drain(2000);
    chk("t6_after_reset_count", 64'(out_count), 64'd162);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
